// File: rtl/ex_div_pkg.sv
// ex_div_pkg: state, handshake and EX opcode encodings shared by the EX-stage divider
package ex_div_pkg;
    typedef enum logic [1:0] {DIV_FREE, DIV_BY_ZERO, DIV_ON, DIV_END} div_state_e;
    localparam logic DIV_RESULT_READY = 1'b1;
    localparam logic DIV_RESULT_NOT_READY = 1'b0;
    localparam logic DIV_START = 1'b1;
    localparam logic DIV_STOP = 1'b0;
    localparam logic [7:0] EXE_DIV_OP = 8'b00011010;
    localparam logic [7:0] EXE_DIVU_OP = 8'b00011011;
    localparam logic [2:0] EXE_RES_DIV = 3'b110;
endpackage

// File: rtl/ex_div_if.sv
// ex_div_if: request/result bundle between the EX stage (master) and the divider (slave)
interface ex_div_if #(parameter int WIDTH = 32);
    logic start_i;
    logic signed_i;
    logic annul_i;
    logic [WIDTH-1:0] opdata1_i;
    logic [WIDTH-1:0] opdata2_i;
    logic [2*WIDTH-1:0] result_o;
    logic ready_o;
    logic busy_o;
    modport master(output start_i, signed_i, annul_i, opdata1_i, opdata2_i, input result_o, ready_o, busy_o);
    modport slave(input start_i, signed_i, annul_i, opdata1_i, opdata2_i, output result_o, ready_o, busy_o);
endinterface

// File: rtl/ex_div_step.sv
// ex_div_step: one restoring iteration on the {remainder, quotient} partial register
module ex_div_step #(parameter int WIDTH = 32) (
    input  logic [2*WIDTH:0]  partial_i,
    input  logic [WIDTH-1:0]  divisor_i,
    output logic [2*WIDTH:0]  partial_o
);
    logic [WIDTH+1:0] diff;
    always_comb begin
        diff = partial_i[2*WIDTH:WIDTH-1] - {2'b00, divisor_i};
        partial_o = diff[WIDTH+1] ? {partial_i[2*WIDTH-1:0], 1'b0} : {diff[WIDTH:0], partial_i[WIDTH-2:0], 1'b1};
    end
endmodule

// File: rtl/ex_div.sv
// ex_div: iterative radix-2 restoring divider, signed/unsigned, with annul support
module ex_div
    import ex_div_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input logic clk,
    input logic rst,
    ex_div_if.slave m
);
    localparam int CW = $clog2(WIDTH + 1);
    div_state_e state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [2*WIDTH:0] part_q, part_d, part_nx;
    logic [WIDTH-1:0] dvs_q, dvs_d, abs1, abs2, quo, rem;
    logic negq_q, negq_d, negr_q, negr_d;
    logic [2*WIDTH-1:0] result_q, result_d;
    logic ready_q, ready_d;
    logic go;

    ex_div_step #(.WIDTH(WIDTH)) u_step (
        .partial_i(part_q),
        .divisor_i(dvs_q),
        .partial_o(part_nx)
    );

    assign go = m.start_i & ~m.annul_i;
    assign abs1 = (m.signed_i & m.opdata1_i[WIDTH-1]) ? -m.opdata1_i : m.opdata1_i;
    assign abs2 = (m.signed_i & m.opdata2_i[WIDTH-1]) ? -m.opdata2_i : m.opdata2_i;
    // Sign fix on the magnitude result; MIN/-1 wraps naturally to MIN rem 0
    assign quo = negq_q ? -part_q[WIDTH-1:0] : part_q[WIDTH-1:0];
    assign rem = negr_q ? -part_q[2*WIDTH-1:WIDTH] : part_q[2*WIDTH-1:WIDTH];
    assign m.busy_o = (state_q == DIV_FREE && go) || state_q == DIV_ON || state_q == DIV_BY_ZERO;
    assign m.result_o = result_q;
    assign m.ready_o = ready_q;

    always_comb begin
        state_d = state_q;
        cnt_d = cnt_q;
        part_d = part_q;
        dvs_d = dvs_q;
        negq_d = negq_q;
        negr_d = negr_q;
        result_d = result_q;
        ready_d = ready_q;
        case (state_q)
            DIV_FREE: begin
                result_d = '0;
                ready_d = DIV_RESULT_NOT_READY;
                if (go) begin
                    state_d = (m.opdata2_i == '0) ? DIV_BY_ZERO : DIV_ON;
                    cnt_d = '0;
                    part_d = {{(WIDTH+1){1'b0}}, abs1};
                    dvs_d = abs2;
                    negq_d = m.signed_i & (m.opdata1_i[WIDTH-1] ^ m.opdata2_i[WIDTH-1]);
                    negr_d = m.signed_i & m.opdata1_i[WIDTH-1];
                end
            end
            DIV_BY_ZERO: begin
                state_d = m.annul_i ? DIV_FREE : DIV_END;
                result_d = '0;
                ready_d = m.annul_i ? DIV_RESULT_NOT_READY : DIV_RESULT_READY;
            end
            DIV_ON: begin
                if (m.annul_i) begin
                    state_d = DIV_FREE;
                    result_d = '0;
                    ready_d = DIV_RESULT_NOT_READY;
                end else if (cnt_q == CW'(WIDTH)) begin
                    state_d = DIV_END;
                    result_d = {rem, quo};
                    ready_d = DIV_RESULT_READY;
                end else begin
                    part_d = part_nx;
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                ready_d = DIV_RESULT_READY;
                if (!m.start_i) begin
                    state_d = DIV_FREE;
                    result_d = '0;
                    ready_d = DIV_RESULT_NOT_READY;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= DIV_FREE;
            cnt_q <= '0;
            part_q <= '0;
            dvs_q <= '0;
            negq_q <= 1'b0;
            negr_q <= 1'b0;
            result_q <= '0;
            ready_q <= DIV_RESULT_NOT_READY;
        end else begin
            state_q <= state_d;
            cnt_q <= cnt_d;
            part_q <= part_d;
            dvs_q <= dvs_d;
            negq_q <= negq_d;
            negr_q <= negr_d;
            result_q <= result_d;
            ready_q <= ready_d;
        end
    end
endmodule

// File: tb/tb_ex_div.sv
// tb_ex_div: directed-vector bench for ex_div at WIDTH=32
module tb_ex_div;
    import ex_div_pkg::*;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int n_chk = 0;
    int n_fail = 0;

    ex_div_if #(.WIDTH(32)) bus();
    ex_div #(.WIDTH(32)) dut (.clk(clk), .rst(rst), .m(bus));

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // lat counts edges from raising start_i until ready_o, and equals the number of busy cycles
    task automatic div_run(input string tag, input logic sgn, input logic [31:0] a, input logic [31:0] b,
                           input logic [63:0] exp, input int lat, input int hold);
        int n = 0;
        int nb = 0;
        bus.start_i = 1'b1;
        bus.signed_i = sgn;
        bus.opdata1_i = a;
        bus.opdata2_i = b;
        #1;
        if (bus.busy_o) nb++;
        while (!bus.ready_o && n < 100) begin
            tick();
            n++;
            if (n == 1) begin
                bus.opdata1_i = 32'hDEADBEEF;
                bus.opdata2_i = 32'h0000_0003;
                bus.signed_i = ~sgn;
            end
            #1;
            if (!bus.ready_o && bus.busy_o) nb++;
        end
        check({tag, " latency"}, 64'(n), 64'(lat));
        check({tag, " busy cycles"}, 64'(nb), 64'(lat));
        check({tag, " result"}, bus.result_o, exp);
        check({tag, " busy in ready"}, 64'(bus.busy_o), 64'd0);
        for (int h = 0; h < hold; h++) begin
            tick();
            check({tag, " hold ready"}, 64'(bus.ready_o), 64'd1);
            check({tag, " hold result"}, bus.result_o, exp);
        end
        bus.start_i = 1'b0;
        tick();
        check({tag, " ready drop"}, 64'(bus.ready_o), 64'd0);
        check({tag, " result clear"}, bus.result_o, 64'd0);
    endtask

    initial begin
        logic seen;
        bus.start_i = 1'b0;
        bus.signed_i = 1'b0;
        bus.annul_i = 1'b0;
        bus.opdata1_i = '0;
        bus.opdata2_i = '0;
        tick();
        tick();
        check("reset result", bus.result_o, 64'd0);
        check("reset ready", 64'(bus.ready_o), 64'd0);
        check("reset busy", 64'(bus.busy_o), 64'd0);
        rst = 1'b0;
        tick();

        div_run("u 100/7", 1'b0, 32'd100, 32'd7, {32'd2, 32'd14}, 34, 3);
        div_run("s -7/2", 1'b1, 32'hFFFFFFF9, 32'd2, {32'hFFFFFFFF, 32'hFFFFFFFD}, 34, 0);
        div_run("s 7/-2", 1'b1, 32'd7, 32'hFFFFFFFE, {32'h00000001, 32'hFFFFFFFD}, 34, 0);
        div_run("s -100/-7", 1'b1, 32'hFFFFFF9C, 32'hFFFFFFF9, {32'hFFFFFFFE, 32'd14}, 34, 0);
        div_run("div0", 1'b0, 32'h1234, 32'd0, 64'd0, 2, 1);
        div_run("s min/-1", 1'b1, 32'h80000000, 32'hFFFFFFFF, {32'h0, 32'h80000000}, 34, 0);
        div_run("u max/1", 1'b0, 32'hFFFFFFFF, 32'd1, {32'h0, 32'hFFFFFFFF}, 34, 0);
        div_run("u min/max", 1'b0, 32'h80000000, 32'hFFFFFFFF, {32'h80000000, 32'h0}, 34, 0);

        bus.annul_i = 1'b1;
        bus.start_i = 1'b1;
        bus.opdata1_i = 32'd100;
        bus.opdata2_i = 32'd7;
        #1;
        check("annul blocks busy", 64'(bus.busy_o), 64'd0);
        tick();
        check("annul blocks start", 64'(bus.busy_o), 64'd0);
        bus.annul_i = 1'b0;
        #1;
        tick();
        for (int i = 0; i < 10; i++) tick();
        check("busy before annul", 64'(bus.busy_o), 64'd1);
        bus.annul_i = 1'b1;
        bus.start_i = 1'b0;
        tick();
        bus.annul_i = 1'b0;
        #1;
        check("annul busy drop", 64'(bus.busy_o), 64'd0);
        seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (bus.ready_o) seen = 1'b1;
        end
        check("annul no ready", 64'(seen), 64'd0);
        div_run("u 45/9", 1'b0, 32'd45, 32'd9, {32'd0, 32'd5}, 34, 0);

        bus.start_i = 1'b1;
        bus.signed_i = 1'b0;
        bus.opdata1_i = 32'd1000;
        bus.opdata2_i = 32'd3;
        tick();
        for (int i = 0; i < 5; i++) tick();
        rst = 1'b1;
        bus.start_i = 1'b0;
        tick();
        check("rst ready", 64'(bus.ready_o), 64'd0);
        check("rst result", bus.result_o, 64'd0);
        check("rst busy", 64'(bus.busy_o), 64'd0);
        check("rst state", 64'(dut.state_q), 64'(DIV_FREE));
        rst = 1'b0;
        tick();
        div_run("u 1000/3", 1'b0, 32'd1000, 32'd3, {32'd1, 32'd333}, 34, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
